// File: rtl/tile_buffer.sv
// ---------------------------------------------------------------------------
// tile_buffer
//
// Tile-granular on-chip buffer placed directly behind the DRAM tile loader.
// A capture session starts with wr_start, which loads the first slot index
// from wr_base. Each tile_valid strobe then stores one TILE_WIDTH-bit tile in
// the next consecutive slot, with wrap-around from DEPTH-1 to 0. The session
// ends when the loader raises load_done, and done pulses for one cycle.
// A separate registered read port serves the compute datapath in every state.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   wr_start      one-cycle pulse that (re)starts a capture session
//   wr_base       first slot index, sampled together with wr_start
//   tile_in       tile data from the loader
//   tile_valid    one-cycle tile strobe from the loader
//   load_done     loader end-of-transfer (may coincide with the last tile)
//   rd_en         read request
//   rd_addr       slot to read
//   rd_data       registered read data (holds when no read is issued)
//   rd_valid      high the cycle after an accepted rd_en
//   busy          high while a session is capturing tiles
//   done          one-cycle completion pulse
//   tiles_written tiles stored in the current or last session (saturates)
//   overflow      sticky: a tile was dropped because the buffer was full
// ---------------------------------------------------------------------------
module tile_buffer #(
   parameter int TILE_WIDTH = 256,
   parameter int DEPTH      = 64,
   parameter int IDX_W      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_start,
   input  logic [IDX_W-1:0]      wr_base,
   input  logic [TILE_WIDTH-1:0] tile_in,
   input  logic                  tile_valid,
   input  logic                  load_done,
   input  logic                  rd_en,
   input  logic [IDX_W-1:0]      rd_addr,
   output logic [TILE_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  busy,
   output logic                  done,
   output logic [IDX_W:0]        tiles_written,
   output logic                  overflow
);

   localparam int             LANES      = TILE_WIDTH / 8;
   localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITING = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t             state_reg;
   state_t             state_next;
   logic [IDX_W-1:0]   wr_ptr_reg;
   logic [IDX_W:0]     tiles_written_reg;
   logic               overflow_reg;
   logic               rd_valid_reg;

   logic               buffer_full;
   logic               tile_accept;
   logic               tile_drop;

   // A restart outranks a coincident tile strobe, so tiles are only taken
   // in WRITING when no wr_start is present in the same cycle.
   assign buffer_full = (tiles_written_reg == FULL_COUNT);
   assign tile_accept = (state_reg == WRITING) && tile_valid && !wr_start && !buffer_full;
   assign tile_drop   = (state_reg == WRITING) && tile_valid && !wr_start &&  buffer_full;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic. wr_start is honoured in every state.
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (wr_start) state_next = WRITING;
         end
         WRITING: begin
            if (wr_start)       state_next = WRITING;
            else if (load_done) state_next = DONE;
         end
         DONE: begin
            // done still pulses this cycle even when a restart arrives
            if (wr_start) state_next = WRITING;
            else          state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs (Moore, taken straight from the state register)
   // ------------------------------------------------------------------
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         WRITING: busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Session bookkeeping: write pointer, tile count, sticky overflow
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg        <= '0;
         tiles_written_reg <= '0;
         overflow_reg      <= 1'b0;
      end else if (wr_start) begin
         wr_ptr_reg        <= wr_base;
         tiles_written_reg <= '0;
         overflow_reg      <= 1'b0;
      end else if (tile_accept) begin
         wr_ptr_reg        <= wr_ptr_reg + 1'b1;   // wraps DEPTH-1 -> 0
         tiles_written_reg <= tiles_written_reg + 1'b1;
      end else if (tile_drop) begin
         overflow_reg      <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Read-valid flag
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_en;
      end
   end

   // ------------------------------------------------------------------
   // Storage, split into byte lanes. Each lane is a simple dual-port RAM
   // with a registered read; a read and a write to the same slot in one
   // cycle returns the old contents (read-before-write).
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [7:0] mem_lane [DEPTH];
         logic [7:0] rd_lane_reg;

         always_ff @(posedge clk) begin
            if (tile_accept) begin
               mem_lane[wr_ptr_reg] <= tile_in[gi*8 +: 8];
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_lane_reg <= '0;
            end else if (rd_en) begin
               rd_lane_reg <= mem_lane[rd_addr];
            end
         end

         assign rd_data[gi*8 +: 8] = rd_lane_reg;
      end
   endgenerate

   assign rd_valid      = rd_valid_reg;
   assign tiles_written = tiles_written_reg;
   assign overflow      = overflow_reg;

endmodule
